// File: rtl/stopwatch_pkg.sv
// Shared widths, default wrap limits and FSM state type for the stopwatch.
// Imported by the time core, its counter and its interface.
package stopwatch_pkg;

  localparam int TIME_W      = 6;
  localparam int DEF_MAX_MIN = 59;
  localparam int DEF_MAX_SEC = 59;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    ADJ   = 2'd2
  } sw_state_t;

endpackage

// File: rtl/stopwatch_time_core_if.sv
// Control pulses in, time/status out, between the stopwatch front end and core.
// master: tick/pulse/level source; slave: stopwatch_time_core.
interface stopwatch_time_core_if;
  import stopwatch_pkg::*;

  logic              tick_1hz;
  logic              tick_2hz;
  logic              adj;
  logic              sel;
  logic              pause_pulse;
  logic              clear_pulse;
  logic [TIME_W-1:0] minutes;
  logic [TIME_W-1:0] seconds;
  logic              running;
  logic              blink_min;
  logic              blink_sec;

  modport master (
    output tick_1hz, tick_2hz, adj, sel,
    output pause_pulse, clear_pulse,
    input  minutes, seconds, running,
    input  blink_min, blink_sec
  );

  modport slave (
    input  tick_1hz, tick_2hz, adj, sel,
    input  pause_pulse, clear_pulse,
    output minutes, seconds, running,
    output blink_min, blink_sec
  );

endinterface

// File: rtl/wrap_counter.sv
// Up counter 0..MAX that wraps to 0; clr wins over inc.
// Ports: clk, rst_n, inc, clr in; value (registered), at_max (comb) out.
module wrap_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = DEF_MAX_SEC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [TIME_W-1:0] value,
  output logic              at_max
);

  assign at_max = (value == TIME_W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_time_core.sv
// Stopwatch minutes/seconds with PAUSE/RUN/ADJ control; optional field
// blink when STOPWATCH_BLINK_EN is defined. Ports: clk, rst_n, bus (slave).
module stopwatch_time_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = DEF_MAX_MIN,
  parameter int MAX_SEC = DEF_MAX_SEC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stopwatch_time_core_if.slave  bus
);

  sw_state_t         state;
  sw_state_t         state_nx;
  logic              resume_run;
  logic              resume_nx;
  logic              sec_inc;
  logic              min_inc;
  logic              sec_max;
  logic              unused_min_max;
  logic [TIME_W-1:0] sec_val;
  logic [TIME_W-1:0] min_val;
  logic              run_q;
  logic              blink_min;
  logic              blink_sec;

  // Clear holds the state; otherwise adj edges, then pause,
  // then ticks, each masking everything below it.
  always_comb begin
    state_nx  = state;
    resume_nx = resume_run;
    sec_inc   = 1'b0;
    min_inc   = 1'b0;
    if (bus.clear_pulse) begin
      state_nx = state;
    end else if (state != ADJ && bus.adj) begin
      state_nx  = ADJ;
      resume_nx = (state == RUN);
    end else if (state == ADJ && !bus.adj) begin
      state_nx = resume_run ? RUN : PAUSE;
    end else if (state == ADJ) begin
      if (bus.tick_2hz) begin
        sec_inc = bus.sel;
        min_inc = !bus.sel;
      end
    end else if (bus.pause_pulse) begin
      state_nx = (state == RUN) ? PAUSE : RUN;
    end else if (state == RUN && bus.tick_1hz) begin
      sec_inc = 1'b1;
      min_inc = sec_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PAUSE;
      resume_run <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      resume_run <= resume_nx;
      run_q      <= (state_nx == RUN);
    end
  end

  wrap_counter #(.MAX(MAX_SEC)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (sec_inc),
    .clr    (bus.clear_pulse),
    .value  (sec_val),
    .at_max (sec_max)
  );

  wrap_counter #(.MAX(MAX_MIN)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (min_inc),
    .clr    (bus.clear_pulse),
    .value  (min_val),
    .at_max (unused_min_max)
  );

`ifdef STOPWATCH_BLINK_EN
  logic phase;
  logic phase_nx;

  always_comb begin
    phase_nx = phase;
    if (state != ADJ && state_nx == ADJ) begin
      phase_nx = 1'b0;
    end else if (state == ADJ && state_nx == ADJ &&
                 bus.tick_2hz && !bus.clear_pulse) begin
      phase_nx = ~phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
    end else begin
      phase     <= phase_nx;
      blink_sec <= (state_nx == ADJ) & bus.sel & phase_nx;
      blink_min <= (state_nx == ADJ) & !bus.sel & phase_nx;
    end
  end
`else
  assign blink_min = 1'b0;
  assign blink_sec = 1'b0;
`endif

  assign bus.minutes   = min_val;
  assign bus.seconds   = sec_val;
  assign bus.running   = run_q;
  assign bus.blink_min = blink_min;
  assign bus.blink_sec = blink_sec;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Directed self-checking bench for stopwatch_time_core.
// Blink checks follow STOPWATCH_BLINK_EN.
module tb_stopwatch_time_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  stopwatch_time_core_if sw_if ();

  stopwatch_time_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int mm, input int ss);
    chk(tag, int'(sw_if.minutes) * 100 + int'(sw_if.seconds),
        mm * 100 + ss);
  endtask

  task automatic cyc(input logic t1, input logic t2,
                     input logic pp, input logic cp);
    sw_if.tick_1hz    = t1;
    sw_if.tick_2hz    = t2;
    sw_if.pause_pulse = pp;
    sw_if.clear_pulse = cp;
    @(posedge clk);
    #1;
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_2hz    = 1'b0;
    sw_if.pause_pulse = 1'b0;
    sw_if.clear_pulse = 1'b0;
  endtask

  task automatic ticks1(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  task automatic ticks2(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask

  task automatic set_adj(input logic a, input logic s);
    sw_if.adj = a;
    sw_if.sel = s;
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_2hz    = 1'b0;
    sw_if.adj         = 1'b0;
    sw_if.sel         = 1'b0;
    sw_if.pause_pulse = 1'b0;
    sw_if.clear_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_time("rst_time", 0, 0);
    chk("rst_running", int'(sw_if.running), 0);
    chk("rst_blink_min", int'(sw_if.blink_min), 0);
    chk("rst_blink_sec", int'(sw_if.blink_sec), 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // start and count three seconds
    cyc(0, 0, 1, 0);
    chk("start_running", int'(sw_if.running), 1);
    ticks1(3);
    chk_time("count3", 0, 3);

    // preload 00:59 from RUN, resume, carry into minutes
    set_adj(1, 1);
    chk("adj_entry_running", int'(sw_if.running), 0);
    chk_time("adj_entry_time", 0, 3);
    ticks2(56);
    chk_time("preload_059", 0, 59);
    set_adj(0, 1);
    chk("resume_running", int'(sw_if.running), 1);
    ticks1(1);
    chk_time("carry_100", 1, 0);

    // preload 59:59 and roll over
    set_adj(1, 0);
    ticks2(58);
    chk_time("preload_min59", 59, 0);
    sw_if.sel = 1'b1;
    ticks2(59);
    chk_time("preload_5959", 59, 59);
    set_adj(0, 1);
    ticks1(1);
    chk_time("rollover", 0, 0);
    chk("rollover_running", int'(sw_if.running), 1);

    // seconds wrap in adjust does not carry
    ticks1(10);
    chk_time("run_010", 0, 10);
    set_adj(1, 1);
    ticks2(55);
    chk_time("adj_sec_wrap", 0, 5);
    set_adj(0, 1);
    chk("resume2_running", int'(sw_if.running), 1);
    ticks1(1);
    chk_time("resume_006", 0, 6);

    // 1 Hz ignored in ADJ, pause ignored in ADJ
    set_adj(1, 0);
    cyc(1, 1, 0, 0);
    chk_time("adj_both_ticks", 1, 6);
    cyc(0, 0, 1, 0);
    chk("adj_pause_ign", int'(sw_if.running), 0);
    chk_time("adj_pause_time", 1, 6);
    set_adj(0, 0);
    chk("adj_exit_run", int'(sw_if.running), 1);

    // clear with a tick at 12:34 in RUN
    set_adj(1, 0);
    ticks2(11);
    sw_if.sel = 1'b1;
    ticks2(28);
    chk_time("preload_1234", 12, 34);
    set_adj(0, 1);
    cyc(1, 0, 0, 1);
    chk_time("clear_tick", 0, 0);
    chk("clear_running", int'(sw_if.running), 1);
    ticks1(1);
    chk_time("after_clear", 0, 1);

    // tick with pause is not counted; paused stays frozen
    cyc(1, 0, 1, 0);
    chk("pause_running", int'(sw_if.running), 0);
    chk_time("pause_tick", 0, 1);
    ticks1(2);
    chk_time("paused_frozen", 0, 1);

    // pause in the same cycle as adj rising is dropped
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b1;
    cyc(0, 0, 1, 0);
    set_adj(0, 1);
    chk("adj_from_pause", int'(sw_if.running), 0);

    // blink behaviour
    set_adj(1, 1);
    chk("blink_entry_sec", int'(sw_if.blink_sec), 0);
    ticks2(1);
`ifdef STOPWATCH_BLINK_EN
    chk("blink_sec_1", int'(sw_if.blink_sec), 1);
`else
    chk("blink_sec_1", int'(sw_if.blink_sec), 0);
`endif
    chk("blink_min_1", int'(sw_if.blink_min), 0);
    ticks2(1);
    chk("blink_sec_2", int'(sw_if.blink_sec), 0);
    chk("blink_min_2", int'(sw_if.blink_min), 0);
    chk_time("blink_time", 0, 3);

    // asynchronous reset mid-adjust
    ticks2(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("async_rst_time", 0, 0);
    chk("async_rst_running", int'(sw_if.running), 0);
    sw_if.adj = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0);
    chk_time("post_rst_paused", 0, 0);
    cyc(0, 0, 1, 0);
    chk("post_rst_start", int'(sw_if.running), 1);
    ticks1(1);
    chk_time("post_rst_count", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_core.md
# stopwatch_time_core

Owns the stopwatch's minutes/seconds registers and produces the `minutes`/`seconds` values consumed by the select/adjust path and the display. It counts at 1 Hz while running, freezes while paused, and, while `adj` is high, advances only the field chosen by `sel` at 2 Hz. All rate information arrives as single-cycle enable pulses on the one system clock; the block contains no derived clocks.

## Interface
Parameters:
- `MAX_MIN`, 59: highest minutes value before wrap to 0.
- `MAX_SEC`, 59: highest seconds value before wrap to 0.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  one-cycle pulse, 1 Hz count enable.
- `tick_2hz`  in  1  one-cycle pulse, 2 Hz adjust enable.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; 1 = adjust seconds, 0 = adjust minutes.
- `pause_pulse`  in  1  one-cycle, already debounced; toggles run/pause.
- `clear_pulse`  in  1  one-cycle, already debounced; zeroes time.
- `minutes`  out  6  current minutes, registered.
- `seconds`  out  6  current seconds, registered.
- `running`  out  1  1 when in RUN.
- `blink_min`, `blink_sec`  out  1  display blank request for the field being adjusted.

## Operation
- States: PAUSE, RUN, ADJ. Flag `resume_run` records whether ADJ was entered from RUN.
- Reset: `minutes`=0, `seconds`=0, state=PAUSE, `resume_run`=0, `running`=0, blink outputs 0.
- PAUSE: `pause_pulse` → RUN. Time frozen.
- RUN: `pause_pulse` → PAUSE. On `tick_1hz`: seconds+1; at `MAX_SEC` seconds→0 and minutes+1; at `MAX_MIN`:`MAX_SEC` both →0 (59:59 → 00:00).
- Any state with `adj`=1 → ADJ. `resume_run` captures (state==RUN) on entry.
- ADJ: on `tick_2hz`, `sel`=1 → seconds+1, wrapping `MAX_SEC`→0 with no carry; `sel`=0 → minutes+1, wrapping `MAX_MIN`→0. `tick_1hz` and `pause_pulse` are ignored. `sel` may change at any time; it is sampled on each `tick_2hz`.
- `adj` falls → RUN if `resume_run`, otherwise PAUSE.
- Priority, highest first: `clear_pulse` (time→00:00, state unchanged), then the `adj` transition, then `pause_pulse`, then ticks.
- A `pause_pulse` in the same cycle as `adj` rising is dropped. A `clear_pulse` with any tick yields 00:00.
- Values above MAX loaded only through reset are impossible; the counters never exceed MAX.

## Timing
- A tick or pulse sampled at edge N is reflected on outputs immediately after edge N. Latency is one cycle from input assertion to output.
- `running` and the blink outputs are registered and update on the same edge as the state.
- Count updates in RUN take effect on the `tick_1hz` edge. A `tick_1hz` coincident with a RUN→PAUSE `pause_pulse` is not counted.
- Reset assertion clears everything asynchronously, including mid-adjust. Release is synchronous to `clk`, and the first transition is possible on the next edge.

## Configuration
- `STOPWATCH_BLINK_EN` defined: a `phase` bit is cleared on ADJ entry and toggles on each `tick_2hz` in ADJ. `blink_sec` = ADJ & `sel` & `phase`; `blink_min` = ADJ & !`sel` & `phase`.
- Undefined: the phase logic is omitted. `blink_min`/`blink_sec` ports remain and are tied to 0.

## Structure
- Package `stopwatch_pkg` holds:
  - `TIME_W`=6;
  - default `MAX_MIN`/`MAX_SEC`;
  - the state enum `sw_state_t` {PAUSE, RUN, ADJ}.
- Sub-module `wrap_counter`, instantiated twice (minutes, seconds):
  - parameter MAX;
  - inputs `inc`, `clr`;
  - outputs `value` and combinational `at_max`.
- The top level holds the FSM and the carry/select steering.

## Test plan
- Reset → 00:00, `running`=0. `pause_pulse`, then 3 `tick_1hz` → 00:03, `running`=1.
- Preload 00:59 via adjust, RUN, 1 `tick_1hz` → 01:00. From 59:59, 1 `tick_1hz` → 00:00.
- RUN at 00:10, `adj`=1 `sel`=1, 55 `tick_2hz` → 00:05 (seconds wrap, minutes unchanged). Drop `adj` → RUN resumes, next `tick_1hz` → 00:06.
- In ADJ, `sel`=0, `tick_1hz` and `tick_2hz` in the same cycle → minutes+1 only. `pause_pulse` in ADJ → no state change.
- `clear_pulse` coincident with `tick_1hz` at 12:34 in RUN → 00:00, still RUN. `rst_n` low mid-ADJ → 00:00, PAUSE.
- With `STOPWATCH_BLINK_EN`: enter ADJ `sel`=1, 2 `tick_2hz` → `blink_sec` 1 then 0, `blink_min` stays 0. Without the macro, both blink outputs stay 0 throughout.
